// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready output register and error pulses.
// Optional 2-of-3 majority sampling when UART_RX_MAJORITY_EN is defined.
module uart_rx #(
    parameter int CLK_FREQ  = 12_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CW             = $clog2(CYCLES_PER_BIT);
    localparam logic [CW-1:0] START_T = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_T   = CW'(CYCLES_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    state_t        next_state;
    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cycle_count;
    logic [2:0]    bit_index;
    logic [7:0]    shift_reg;
    logic          terminal;
    logic          sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // hist holds rx_s from the two cycles before the sample point
    logic [1:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], sync2};
        end
    end

    assign sample = (hist[1] & hist[0]) | (hist[1] & sync2) | (hist[0] & sync2);
`else
    assign sample = sync2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        terminal   = 1'b0;
        case (state)
            IDLE: begin
                if (!sync2) begin
                    next_state = START;
                end
            end
            START: begin
                terminal = (cycle_count == START_T);
                if (terminal) begin
                    next_state = sample ? IDLE : DATA;
                end
            end
            DATA: begin
                terminal = (cycle_count == BIT_T);
                if (terminal && bit_index == 3'd7) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                terminal = (cycle_count == BIT_T);
                if (terminal) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
            bit_index   <= 3'd0;
            shift_reg   <= 8'h00;
        end else begin
            if (next_state != state || terminal || state == IDLE) begin
                cycle_count <= '0;
            end else begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (state == START && terminal) begin
                bit_index <= 3'd0;
            end else if (state == DATA && terminal) begin
                bit_index <= bit_index + 3'd1;
                shift_reg <= {sample, shift_reg[7:1]};
            end
        end
    end

    // A completing byte may overwrite data only when the slot is free or being accepted now
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end
            if (state == STOP && terminal) begin
                if (!sample) begin
                    frame_err <= 1'b1;
                end else if (!valid || ready) begin
                    data  <= shift_reg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed scoreboard bench for uart_rx.
module tb_uart_rx;

    localparam int CPB = 104;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int start_cyc = 0;
    int n_fe = 0;
    int n_ov = 0;
    int n_vcyc = 0;
    logic valid_q = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx #(.CLK_FREQ(12_000_000), .BAUD_RATE(115200)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .data(data),
        .valid(valid),
        .ready(ready),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            valid_q = 1'b0;
        end else begin
            if (valid && !valid_q) rise_cyc = cyc;
            valid_q = valid;
            if (valid) n_vcyc++;
            if (frame_err) n_fe++;
            if (overrun) n_ov++;
            if (valid && ready) begin
                chk("sb_expected_byte_present", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("sb_data", data, exp_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller is at posedge+#1; rx value driven in step c is seen by the DUT at edge c+1.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit glitch,
                              input int abort_c);
        int bitno;
        logic v;
        start_cyc = cyc;
        for (int c = 0; c < 10 * CPB; c++) begin
            bitno = c / CPB;
            if (bitno == 0) v = 1'b0;
            else if (bitno <= 8) v = b[bitno-1];
            else v = stop_bit;
            if (glitch && bitno >= 1 && bitno <= 8 && (c % CPB) == 52) v = ~v;
            if (c == abort_c) begin
                rst_n = 1'b0;
                rx = 1'b1;
                #1;
                chk("rst_mid_valid", valid, 0);
                chk("rst_mid_data", data, 8'h00);
                chk("rst_mid_frame_err", frame_err, 0);
                chk("rst_mid_overrun", overrun, 0);
                repeat (3) @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            rx = v;
            @(posedge clk);
            #1;
        end
    endtask

    int fe0, ov0, vc0;

    initial begin
        repeat (5) @(posedge clk);
        #1;
        chk("reset_valid", valid, 0);
        chk("reset_data", data, 8'h00);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_overrun", overrun, 0);
        rst_n = 1'b1;
        idle(10);

        // single frame, latency and one-cycle valid
        vc0 = n_vcyc; fe0 = n_fe; ov0 = n_ov;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        idle(20);
        chk("a5_drained", exp_q.size(), 0);
        chk("a5_latency_991pm1", (rise_cyc - start_cyc >= 990) && (rise_cyc - start_cyc <= 992), 1);
        chk("a5_valid_cycles", n_vcyc - vc0, 1);
        chk("a5_no_fe", n_fe - fe0, 0);
        chk("a5_no_ov", n_ov - ov0, 0);

        // back-to-back frames
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
        send_frame(8'h00, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        send_frame(8'h55, 1'b1, 1'b0, -1);
        idle(20);
        chk("b2b_drained", exp_q.size(), 0);
        chk("b2b_no_fe", n_fe - fe0, 0);
        chk("b2b_no_ov", n_ov - ov0, 0);

        // framing error then recovery
        vc0 = n_vcyc;
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        idle(20);
        chk("fe_pulse_count", n_fe - fe0, 1);
        chk("fe_no_valid", n_vcyc - vc0, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        idle(20);
        chk("fe_recover_drained", exp_q.size(), 0);

        // false start glitch
        fe0 = n_fe; vc0 = n_vcyc;
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        idle(200);
        chk("glitch_no_valid", n_vcyc - vc0, 0);
        chk("glitch_no_fe", n_fe - fe0, 0);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1, 1'b0, -1);
        idle(20);
        chk("glitch_recover_drained", exp_q.size(), 0);

        // overrun with ready held low
        ready = 1'b0;
        ov0 = n_ov;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        idle(20);
        chk("ovr_valid_held", valid, 1);
        chk("ovr_data_kept", data, 8'h11);
        chk("ovr_pulse_count", n_ov - ov0, 1);
        ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ovr_valid_cleared", valid, 0);
        chk("ovr_data_after_accept", data, 8'h11);
        chk("ovr_drained", exp_q.size(), 0);
        idle(10);

        // reset in the middle of bit 4
        vc0 = n_vcyc;
        send_frame(8'h99, 1'b1, 1'b0, 5 * CPB + 50);
        idle(50);
        chk("rst_no_valid", n_vcyc - vc0, 0);
        exp_q.push_back(8'h99);
        send_frame(8'h99, 1'b1, 1'b0, -1);
        idle(20);
        chk("rst_recover_drained", exp_q.size(), 0);

        // single-cycle inversion at every data bit centre
`ifdef UART_RX_MAJORITY_EN
        exp_q.push_back(8'h6E);
`else
        exp_q.push_back(8'h91);
`endif
        send_frame(8'h6E, 1'b1, 1'b1, -1);
        idle(20);
        chk("centre_glitch_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, 8N1, LSB first: the receive side of the board's serial link, paired with the existing transmitter.
- Double-flop synchronises the asynchronous rx pin.
- Detects the start bit, confirms it at mid-bit, then samples 8 data bits and the stop bit at bit centres.
- Presents each byte on a valid/ready output register.
- Flags framing errors and overruns.

Parameters:
- CLK_FREQ, 12_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line baud rate.
- Derived localparam CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE (104 at defaults).
- Derived localparam HALF_BIT = CYCLES_PER_BIT / 2 (52).
- Counter width is $clog2(CYCLES_PER_BIT).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; asynchronous; idles high.
- data  output  8  received byte; stable while valid=1.
- valid  output  1  byte available in data.
- ready  input  1  consumer accepts the byte when valid & ready at a clk edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a byte completed while the previous one was unaccepted.

Behaviour:
- Reset (async assert, sync deassert handled upstream): both synchroniser flops=1, state=IDLE, counters=0, data=0, valid=0, frame_err=0, overrun=0.
- Reset mid-frame abandons the frame and produces no output.
- rx_s denotes the output of the 2-flop synchroniser (2-cycle latency).
- cycle_count clears to 0 on every state entry and on every bit boundary.
- Sample point ("terminal") is cycle_count == T. The state or bit advances on that same edge.
- IDLE: when rx_s==0, go to START.
- START: T = HALF_BIT-1.
  - Sample 0: go to DATA, bit_index=0.
  - Sample 1: false start (glitch); return to IDLE, no flags.
- DATA: T = CYCLES_PER_BIT-1.
  - Sampled bit shifts into shift_reg MSB, shifting right, so bit 0 is received first.
  - After bit_index==7 is sampled, go to STOP.
- STOP: T = CYCLES_PER_BIT-1.
  - Sample 1: byte complete.
  - Sample 0: frame_err pulses for 1 cycle, byte discarded.
  - Either way return to IDLE at the same edge, so a following start bit is caught within half a bit.
- Byte complete, output register handling:
  - If valid==0, or valid & ready in the same cycle: data<=shift_reg, valid<=1 the following cycle.
  - If valid==1 & ready==0: overrun pulses for 1 cycle. The new byte is dropped; data and valid are unchanged.
- Handshake:
  - valid clears on the edge where valid & ready.
  - ready is ignored while valid==0.
  - data never changes while valid==1 except via the simultaneous accept+complete case above.
- Latency: valid rises 2 + HALF_BIT + 9*CYCLES_PER_BIT + 1 cycles (±1) after the rx falling edge. That is 991 ±1 at defaults.
- No combinational path from rx or ready to any output.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Every sample point (start, data, stop) uses a 2-of-3 majority of rx_s at cycle_count T-2, T-1 and T.
  - The result is registered at T.
  - Timing and state transitions are unchanged.
- Undefined: single sample of rx_s at T; no vote logic is synthesised.

Test Plan:
- Ready tied 1; send frame 0xA5 at 115200 with exact bit timing -> valid high for exactly 1 cycle with data=0xA5, about 991 cycles after the start edge; frame_err=0, overrun=0.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap, ready=1 -> three valid pulses with data 0x00, 0xFF, 0x55 in order; no flags.
- Frame 0x3C with stop bit driven 0 -> frame_err pulses once; valid never asserts; next frame 0x81 is received correctly.
- rx low pulse of 20 cycles then high -> no valid, no frame_err; receiver back in IDLE; subsequent 0x42 is received.
- Ready held 0; send 0x11 then 0x22 -> valid=1, data=0x11; overrun pulses at 0x22 completion; raise ready -> valid clears, data never becomes 0x22.
- rst_n pulsed low mid-way through bit 4 of frame 0x99 -> outputs 0 immediately; no valid for that frame; next 0x99 received.
- With UART_RX_MAJORITY_EN defined: invert rx for 1 cycle exactly at each data bit centre of 0x6E -> data=0x6E. Without the macro, the same stimulus -> data=0x91.
